char_rom_overlay: RTL and testbench
===================================

# char_rom_overlay

Runtime-programmable patch overlay for the character generator ROM. It holds a table of ENTRIES address/data pairs. Each video fetch address is compared against the table, and the base ROM byte is replaced by the table byte on a hit. It sits between the character ROM and the pixel shifter. It also provides a host-side write port, a sequenced table clear and a saturating hit counter for diagnostics.

## Interface
Parameters:
- ADDR_W, 11, character ROM address width
- DATA_W, 8, character ROM data width
- ENTRIES, 32, number of patch table entries (power of two, ≥2)
- IDX_W, 5, table index width; must equal log2(ENTRIES)
- CNT_W, 16, hit counter width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  ADDR_W  character ROM fetch address
- rom_q  in  DATA_W  base ROM data, aligned with a (same cycle)
- override  in  1  overlay enable for this fetch
- q  out  DATA_W  registered output byte (patched or base)
- patch  out  1  registered; 1 when q came from the table
- wr_en  in  1  table write request
- wr_idx  in  IDX_W  entry to write
- wr_addr  in  ADDR_W  match address for the entry
- wr_data  in  DATA_W  replacement byte
- wr_valid  in  1  valid bit written with the entry (0 deletes the entry)
- wr_ready  out  1  1 when writes are accepted (low during clear)
- clr  in  1  start table clear (pulse)
- busy  out  1  clear in progress
- hit_count  out  CNT_W  saturating count of patched fetches

## Operation
- Table: ENTRIES × {valid, addr[ADDR_W], data[DATA_W]}. Reset asynchronously clears all valid bits. The addr and data fields need no reset.
- Lookup, every cycle: hit = override & ~busy & any(valid[i] & addr[i]==a).
- Priority: the lowest matching index wins when several entries match.
- On a hit: q <= data[winner], patch <= 1.
- Otherwise: q <= rom_q, patch <= 0. This covers no match, override low, or busy high.
- Write: accepted when wr_en & wr_ready. The entry wr_idx takes {wr_valid, wr_addr, wr_data} at that edge.
- wr_ready = ~busy. Writes while busy are dropped, not queued.
- FSM states IDLE and CLEAR:
  - IDLE→CLEAR on clr. The clear index resets to 0 and hit_count resets to 0.
  - In CLEAR, valid[idx] <= 0 on each cycle and idx increments.
  - CLEAR→IDLE after the cycle that clears index ENTRIES-1.
  - clr asserted in CLEAR is ignored.
  - busy = (state==CLEAR).
- hit_count increments by 1 on each cycle in which patch is registered as 1. It holds at 2^CNT_W-1 (no wrap).
- Reset values: q=0, patch=0, busy=0, wr_ready=1 once reset is released, hit_count=0, state=IDLE, all valid=0.

## Timing
- Lookup latency is 1 cycle. a, rom_q and override are sampled at edge N; q and patch are valid after edge N and held until edge N+1.
- Write vs lookup in the same cycle on the same entry: the lookup uses the pre-write contents. The new contents affect lookups from the next cycle.
- Clear takes exactly ENTRIES busy cycles. clr sampled at edge N gives busy=1 after edge N and busy=0 after edge N+ENTRIES.
- During those cycles, lookups return rom_q with patch=0, even for entries not yet cleared.
- clr and wr_en in the same IDLE cycle: the write is performed, then the clear erases it. The table ends empty.
- hit_count sees the patch result one cycle after the lookup edge. A hit registered on the same edge that clr is accepted does not count (the clear wins).
- Reset asserted mid-clear aborts the FSM immediately and all outputs return to reset values asynchronously. When rst is released, the block is IDLE with an empty table.
- The overlay is fully pipelined: back-to-back fetches are supported every cycle, with no stall.

## Test plan
- After reset, with override=1, a=0x100, rom_q=0x3C: next cycle q=0x3C, patch=0, hit_count=0.
- Write idx 3 {1,0x100,0xFF}, then fetch a=0x100 with override=1 and rom_q=0x00: q=0xFF, patch=1, hit_count=1. The same fetch with override=0 gives q=0x00, patch=0.
- Priority: idx 7 {1,0x1A7,0x1F} and idx 2 {1,0x1A7,0xC0}. Fetch 0x1A7 → q=0xC0. Write idx 2 with valid=0, refetch → q=0x1F.
- Same-cycle hazard: entry 0 holds {1,0x200,0xDF}; in one cycle write entry 0 {1,0x200,0xDD} and fetch 0x200. First q=0xDF, a repeat fetch gives q=0xDD.
- Clear: fill all 32 entries, pulse clr. busy is high for exactly 32 cycles, wr_ready is low, every fetch gives patch=0 and writes are ignored. Afterwards, fetching any programmed address gives patch=0 and hit_count=0.
- Saturation and reset: with CNT_W=4, run 20 consecutive hits → hit_count=15. Assert rst in the middle of a clear → q=0, patch=0, busy=0 immediately. After release the table is empty.

Source files
------------

// File: rtl/char_rom_overlay_if.sv
// char_rom_overlay_if: host-side write port of the character ROM patch table
interface char_rom_overlay_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
);
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    modport master (output wr_en, wr_idx, wr_addr, wr_data, wr_valid, input wr_ready);
    modport slave (input wr_en, wr_idx, wr_addr, wr_data, wr_valid, output wr_ready);
endinterface

// File: rtl/char_rom_overlay.sv
// char_rom_overlay: patch table that replaces character ROM bytes on address hits
module char_rom_overlay #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int ENTRIES = 32,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              override,
    output logic [DATA_W-1:0] q,
    output logic              patch,
    input  logic              clr,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_count,
    char_rom_overlay_if.slave wr
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, nxt;
    logic [IDX_W-1:0] idx;
    logic [ENTRIES-1:0] valid;
    logic [ADDR_W-1:0] addr_t [ENTRIES];
    logic [DATA_W-1:0] data_t [ENTRIES];
    logic hit_any, hit, wr_go;
    logic [DATA_W-1:0] sel;
    assign busy = state == CLEAR;
    assign wr.wr_ready = ~busy;
    assign wr_go = wr.wr_en & wr.wr_ready;
    assign hit = override & ~busy & hit_any;
    // Scan high to low so the lowest matching index is the last to win
    always_comb begin
        hit_any = 1'b0;
        sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (valid[i] && addr_t[i] == a) begin
                hit_any = 1'b1;
                sel = data_t[i];
            end
    end
    always_comb begin
        nxt = state;
        if (state == IDLE && clr) nxt = CLEAR;
        if (state == CLEAR && idx == IDX_W'(ENTRIES - 1)) nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            valid <= '0;
            q <= '0;
            patch <= 1'b0;
            hit_count <= '0;
        end else begin
            state <= nxt;
            idx <= (state == CLEAR) ? idx + 1'b1 : '0;
            q <= hit ? sel : rom_q;
            patch <= hit;
            if (wr_go) valid[wr.wr_idx] <= wr.wr_valid;
            if (state == CLEAR) valid[idx] <= 1'b0;
            // A hit registered on the clr edge is seen here in CLEAR and is dropped
            if (state == IDLE && clr) hit_count <= '0;
            else if (state == IDLE && patch && ~&hit_count) hit_count <= hit_count + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_go) begin
            addr_t[wr.wr_idx] <= wr.wr_addr;
            data_t[wr.wr_idx] <= wr.wr_data;
        end
    end
endmodule

// File: tb/tb_char_rom_overlay.sv
// tb_char_rom_overlay: directed scoreboard bench for the character ROM overlay
module tb_char_rom_overlay;
    logic clk = 1'b0;
    logic rst;
    logic [10:0] a;
    logic [7:0] rom_q, q;
    logic override, patch, clr, busy;
    logic [3:0] hit_count;
    int total = 0;
    int bad = 0;
    int hits = 0;
    logic [8:0] sb [$];
    char_rom_overlay_if #(.ADDR_W(11), .DATA_W(8), .IDX_W(5)) wif ();
    char_rom_overlay #(.ADDR_W(11), .DATA_W(8), .ENTRIES(32), .IDX_W(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .a(a), .rom_q(rom_q), .override(override),
        .q(q), .patch(patch), .clr(clr), .busy(busy), .hit_count(hit_count), .wr(wif.slave)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of lookup; expected output is queued before the edge and checked after it
    task automatic fetch(input string tag, input logic [10:0] aa, input logic [7:0] rq,
                         input logic ov, input logic [7:0] eq, input logic ep);
        logic [8:0] e;
        a = aa;
        rom_q = rq;
        override = ov;
        sb.push_back({ep, eq});
        if (ep) hits = (hits == 15) ? 15 : hits + 1;
        @(posedge clk);
        #1;
        wif.wr_en = 1'b0;
        clr = 1'b0;
        e = sb.pop_front();
        chk({tag, ".q"}, 32'(q), 32'(e[7:0]));
        chk({tag, ".patch"}, 32'(patch), 32'(e[8]));
    endtask

    task automatic set_wr(input logic [4:0] idx, input logic [10:0] ad, input logic [7:0] d, input logic v);
        wif.wr_en = 1'b1;
        wif.wr_idx = idx;
        wif.wr_addr = ad;
        wif.wr_data = d;
        wif.wr_valid = v;
    endtask

    task automatic write(input logic [4:0] idx, input logic [10:0] ad, input logic [7:0] d, input logic v);
        set_wr(idx, ad, d, v);
        fetch("wrcyc", 11'h7FF, 8'h5A, 1'b0, 8'h5A, 1'b0);
    endtask

    task automatic check_cnt(input string tag);
        fetch("idle", 11'h000, 8'h00, 1'b0, 8'h00, 1'b0);
        chk(tag, 32'(hit_count), 32'(hits));
    endtask

    initial begin
        rst = 1'b1;
        a = '0;
        rom_q = '0;
        override = 1'b0;
        clr = 1'b0;
        wif.wr_en = 1'b0;
        wif.wr_idx = '0;
        wif.wr_addr = '0;
        wif.wr_data = '0;
        wif.wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.q", 32'(q), 32'h0);
        chk("rst.patch", 32'(patch), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.cnt", 32'(hit_count), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst.ready", 32'(wif.wr_ready), 32'h1);

        fetch("miss", 11'h100, 8'h3C, 1'b1, 8'h3C, 1'b0);
        check_cnt("miss.cnt");

        write(5'd3, 11'h100, 8'hFF, 1'b1);
        fetch("hit", 11'h100, 8'h00, 1'b1, 8'hFF, 1'b1);
        fetch("ovoff", 11'h100, 8'h00, 1'b0, 8'h00, 1'b0);
        check_cnt("hit.cnt");

        write(5'd7, 11'h1A7, 8'h1F, 1'b1);
        write(5'd2, 11'h1A7, 8'hC0, 1'b1);
        fetch("prio", 11'h1A7, 8'h55, 1'b1, 8'hC0, 1'b1);
        write(5'd2, 11'h1A7, 8'hC0, 1'b0);
        fetch("prio.del", 11'h1A7, 8'h55, 1'b1, 8'h1F, 1'b1);

        write(5'd0, 11'h200, 8'hDF, 1'b1);
        set_wr(5'd0, 11'h200, 8'hDD, 1'b1);
        fetch("haz.old", 11'h200, 8'h11, 1'b1, 8'hDF, 1'b1);
        fetch("haz.new", 11'h200, 8'h11, 1'b1, 8'hDD, 1'b1);
        check_cnt("haz.cnt");

        for (int i = 0; i < 32; i++) write(5'(i), 11'h400 + 11'(i), 8'(i) ^ 8'hA5, 1'b1);
        fetch("fill", 11'h405, 8'h00, 1'b1, 8'hA0, 1'b1);
        fetch("fill.lo", 11'h400, 8'h00, 1'b1, 8'hA5, 1'b1);
        check_cnt("fill.cnt");

        clr = 1'b1;
        hits = 0;
        fetch("clr", 11'h000, 8'h77, 1'b0, 8'h77, 1'b0);
        for (int k = 0; k < 32; k++) begin
            chk("clr.busy", 32'(busy), 32'h1);
            chk("clr.ready", 32'(wif.wr_ready), 32'h0);
            set_wr(5'd0, 11'h500, 8'h99, 1'b1);
            clr = (k == 10);
            fetch("clr.fetch", 11'h400 + 11'(k), 8'(k), 1'b1, 8'(k), 1'b0);
        end
        chk("clr.done", 32'(busy), 32'h0);
        chk("clr.cnt", 32'(hit_count), 32'h0);
        for (int i = 0; i < 32; i++) fetch("after", 11'h400 + 11'(i), 8'h33, 1'b1, 8'h33, 1'b0);
        fetch("dropwr", 11'h500, 8'h44, 1'b1, 8'h44, 1'b0);
        check_cnt("after.cnt");

        write(5'd1, 11'h123, 8'h5A, 1'b1);
        for (int i = 0; i < 20; i++) fetch("sat", 11'h123, 8'h00, 1'b1, 8'h5A, 1'b1);
        check_cnt("sat.cnt");

        clr = 1'b1;
        hits = 0;
        fetch("clr2", 11'h000, 8'hEE, 1'b0, 8'hEE, 1'b0);
        repeat (5) fetch("clr2.run", 11'h123, 8'hEE, 1'b1, 8'hEE, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst.q", 32'(q), 32'h0);
        chk("arst.patch", 32'(patch), 32'h0);
        chk("arst.busy", 32'(busy), 32'h0);
        chk("arst.cnt", 32'(hit_count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fetch("post", 11'h123, 8'h42, 1'b1, 8'h42, 1'b0);
        fetch("post2", 11'h405, 8'h43, 1'b1, 8'h43, 1'b0);
        chk("post.busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
